// File: rtl/neopixel_frame_arbiter.sv
// ---------------------------------------------------------------------------
// neopixel_frame_arbiter
//
// Shares one neopixel driver between NREQ frame producers (round feedback,
// pattern-load status, game-over display). One-cycle update requests are
// latched into a pending mask. The driver is granted round-robin, kicked with
// a one-cycle start, and then the arbiter waits for its done. After every
// frame an idle gap of GAP_CYCLES keeps the WS2812 latch time. A watchdog
// aborts a frame whose done never arrives and raises a sticky error flag.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high
//   req          per-requester update pulse (bit i = requester i)
//   drv_done     driver finished the current frame (pulse or level)
//   clr_err      clears timeout_err
//   drv_start    one-cycle start strobe to the driver
//   grant        one-hot frame-source select (zero outside START/WAIT)
//   grant_id     binary index of grant
//   pending      latched requests not yet served
//   busy         arbiter is not IDLE
//   timeout_err  sticky watchdog flag
// ---------------------------------------------------------------------------
module neopixel_frame_arbiter #(
    parameter int NREQ       = 3,
    parameter int GAP_CYCLES = 2500,
    parameter int TIMEOUT    = 100000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic                    drv_done,
    input  logic                    clr_err,
    output logic                    drv_start,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [NREQ-1:0]         pending,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int SW  = IDW + 1;
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [GW-1:0]   GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [TW-1:0]   WD_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t          state_r;
    logic [NREQ-1:0] pending_r;
    logic [NREQ-1:0] grant_r;
    logic [IDW-1:0]  grant_id_r;
    logic [IDW-1:0]  last_r;
    logic            drv_start_r;
    logic            busy_r;
    logic            timeout_err_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [TW-1:0]   wd_cnt_r;

    logic            win_found_s;
    logic [IDW-1:0]  win_id_s;
    logic [NREQ-1:0] win_onehot_s;
    logic            take_s;
    logic            timeout_hit_s;

    // Index `offs` positions above `base`, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offs);
        logic [SW-1:0] sum;
        sum = {1'b0, base} + SW'(offs);
        return (sum >= SW'(NREQ)) ? IDW'(sum - SW'(NREQ)) : IDW'(sum);
    endfunction

    // Round-robin winner: first pending bit scanning upward from last+1, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found_s && pending_r[rr_index(last_r, k)]) begin
                win_found_s = 1'b1;
                win_id_s    = rr_index(last_r, k);
            end else begin
                win_found_s = win_found_s;
                win_id_s    = win_id_s;
            end
        end
    end

    assign win_onehot_s  = ONE_HOT0 << win_id_s;
    assign take_s        = (state_r == ST_IDLE) && win_found_s;
    // drv_done has priority over a watchdog expiry in the same cycle.
    assign timeout_hit_s = (state_r == ST_WAIT) && !drv_done && (wd_cnt_r == WD_LAST);

    // Arbitration FSM with registered grant, start strobe, busy and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            grant_id_r  <= '0;
            last_r      <= ID_LAST;
            drv_start_r <= 1'b0;
            busy_r      <= 1'b0;
            gap_cnt_r   <= '0;
            wd_cnt_r    <= '0;
        end else begin
            drv_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        state_r     <= ST_START;
                        grant_r     <= win_onehot_s;
                        grant_id_r  <= win_id_s;
                        last_r      <= win_id_s;
                        drv_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        grant_r    <= '0;
                        grant_id_r <= '0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_START: begin
                    // drv_done is deliberately ignored here.
                    state_r  <= ST_WAIT;
                    wd_cnt_r <= '0;
                end
                ST_WAIT: begin
                    if (drv_done || timeout_hit_s) begin
                        grant_r    <= '0;
                        grant_id_r <= '0;
                        wd_cnt_r   <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= GAP_LOAD;
                        end
                    end else begin
                        wd_cnt_r <= wd_cnt_r + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == '0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= '0;
                    grant_id_r <= '0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Pending mask: new requests OR in; the winner clears unless it re-requests this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r <= '0;
        end else if (take_s) begin
            pending_r <= (pending_r & ~win_onehot_s) | req;
        end else begin
            pending_r <= pending_r | req;
        end
    end

    // Sticky watchdog flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            timeout_err_r <= 1'b1;
        end else if (clr_err) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    // The start strobe is masked while reset is high so a reset landing in START cannot kick the driver.
    assign drv_start   = drv_start_r & ~reset;
    assign grant       = grant_r;
    assign grant_id    = grant_id_r;
    assign pending     = pending_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_neopixel_frame_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for neopixel_frame_arbiter (NREQ=3, GAP_CYCLES=4,
// TIMEOUT=16). A timestamp-based reference model (frame owner, start cycle,
// first cycle arbitration is allowed again) predicts every output each cycle;
// directed scenarios add literal expectations, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_neopixel_frame_arbiter;

    localparam int NREQ = 3;
    localparam int GAP  = 4;
    localparam int TMO  = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            drv_done = 1'b0;
    logic            clr_err = 1'b0;
    logic            drv_start;
    logic [NREQ-1:0] grant;
    logic [1:0]      grant_id;
    logic [NREQ-1:0] pending;
    logic            busy;
    logic            timeout_err;

    always #5 clock = ~clock;

    neopixel_frame_arbiter #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .drv_done    (drv_done),
        .clr_err     (clr_err),
        .drv_start   (drv_start),
        .grant       (grant),
        .grant_id    (grant_id),
        .pending     (pending),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state (describes the cycle about to be observed).
    logic [NREQ-1:0] m_pend;
    int              m_owner;      // requester holding the driver, -1 if none
    int              m_s;          // cycle of drv_start for the current frame
    int              m_idle_from;  // first cycle arbitration may happen
    int              m_last;
    logic            m_err;

    // Expectations for the current cycle.
    logic [NREQ-1:0] e_grant;
    logic [NREQ-1:0] e_pend;
    logic [1:0]      e_gid;
    logic            e_start;
    logic            e_busy;
    logic            e_err;
    logic            e_valid = 1'b0;
    logic            prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend      = '0;
        m_owner     = -1;
        m_s         = 0;
        m_idle_from = 0;
        m_last      = NREQ - 1;
        m_err       = 1'b0;
    endtask

    // Advance the model by one cycle given this cycle's inputs.
    task automatic model_update(input logic [NREQ-1:0] r, input logic d, input logic c, input logic rs);
        logic [NREQ-1:0] np;
        bit tmo;
        tmo = 1'b0;
        if (rs) begin
            model_reset();
        end else begin
            np = m_pend | r;
            if (m_owner >= 0) begin
                if (cyc > m_s) begin
                    if (d) begin
                        m_owner     = -1;
                        m_idle_from = cyc + 1 + GAP;
                    end else if (cyc - m_s == TMO) begin
                        m_owner     = -1;
                        m_idle_from = cyc + 1 + GAP;
                        tmo         = 1'b1;
                    end
                end
            end else if (cyc >= m_idle_from && m_pend != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_pend[(m_last + k) % NREQ]) begin
                        m_owner = (m_last + k) % NREQ;
                        break;
                    end
                end
                m_s         = cyc + 1;
                m_last      = m_owner;
                np[m_owner] = r[m_owner];
            end
            m_pend = np;
            if (tmo) m_err = 1'b1;
            else if (c) m_err = 1'b0;
        end
    endtask

    // One clock cycle: publish expectations, drive inputs, advance model.
    task automatic step(input logic [NREQ-1:0] r, input logic d, input logic c, input logic rs);
        @(posedge clock);
        #1;
        cyc++;
        e_grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        e_gid   = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        e_start = (m_owner >= 0) && (cyc == m_s) && !rs;
        e_busy  = (m_owner >= 0) || (cyc < m_idle_from);
        e_pend  = m_pend;
        e_err   = m_err;
        e_valid = 1'b1;
        reset    = rs;
        req      = r;
        drv_done = d;
        clr_err  = c;
        model_update(r, d, c, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0);
    endtask

    // Step until drv_start (bounded), then check which source was granted.
    task automatic wait_start(input logic [NREQ-1:0] exp_g, input string name);
        int n;
        n = 0;
        step('0, 1'b0, 1'b0, 1'b0);
        while (drv_start !== 1'b1 && n < 60) begin
            step('0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk({name, "_seen"}, drv_start, 1);
        chk({name, "_grant"}, grant, exp_g);
    endtask

    // Called in the start cycle: driver reports done n cycles later.
    task automatic finish_frame(input int n);
        idle(n - 1);
        step('0, 1'b1, 1'b0, 1'b0);
    endtask

    // Compare process: every output against the model, every cycle.
    always @(negedge clock) begin
        if (e_valid) begin
            chk("drv_start", drv_start, e_start);
            chk("grant", grant, e_grant);
            chk("grant_id", grant_id, e_gid);
            chk("pending", pending, e_pend);
            chk("busy", busy, e_busy);
            chk("timeout_err", timeout_err, e_err);
            if (drv_start === 1'b1) chk("start_not_back_to_back", prev_start, 0);
            prev_start = drv_start;
        end
    end

    initial begin
        int t0;
        int s;
        logic [NREQ-1:0] r;
        logic d, c, rs;

        model_reset();

        // Reset state
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        chk("rst_grant", grant, 0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_start", drv_start, 0);
        idle(2);

        // Simultaneous requests: served 0, 1, 2 in order
        step(3'b111, 1'b0, 1'b0, 1'b0);
        wait_start(3'b001, "sim0");
        finish_frame(3);
        wait_start(3'b010, "sim1");
        finish_frame(3);
        wait_start(3'b100, "sim2");
        chk("sim_pending_empty", pending, 0);
        finish_frame(3);
        idle(GAP + 2);

        // Single request: start at t0+2, done at t0+5, busy through t0+9
        step(3'b001, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        idle(2);
        chk("single_start", drv_start, 1);
        chk("single_grant", grant, 3'b001);
        chk("single_gid", grant_id, 0);
        chk("pin_model_start", e_start, 1);
        idle(2);
        step('0, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("single_busy_t9", busy, 1);
        chk("pin_model_busy_t9", e_busy, 1);
        idle(1);
        chk("single_idle_t10", busy, 0);
        chk("pin_model_idle_t10", e_busy, 0);
        chk("single_elapsed", cyc - t0, 10);
        idle(2);

        // Fairness: after serving 1, req 0 and 1 during gap -> 0 then 1
        step(3'b010, 1'b0, 1'b0, 1'b0);
        wait_start(3'b010, "fair_a");
        finish_frame(3);
        step(3'b011, 1'b0, 1'b0, 1'b0);
        wait_start(3'b001, "fair_b");
        finish_frame(3);
        wait_start(3'b010, "fair_c");
        finish_frame(3);
        idle(GAP + 2);

        // Re-request while being served
        step(3'b001, 1'b0, 1'b0, 1'b0);
        wait_start(3'b001, "rereq_a");
        step(3'b001, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("rereq_pending", pending, 3'b001);
        step('0, 1'b1, 1'b0, 1'b0);
        wait_start(3'b001, "rereq_b");
        finish_frame(3);
        idle(GAP + 2);

        // Watchdog: no done for requester 1; requester 0 queued behind it
        step(3'b010, 1'b0, 1'b0, 1'b0);
        wait_start(3'b010, "wd_a");
        s = cyc;
        step(3'b001, 1'b0, 1'b0, 1'b0);
        idle(14);
        chk("wd_still_waiting", grant, 3'b010);
        idle(1);
        chk("wd_last_wait_cycle", cyc - s, TMO);
        idle(1);
        chk("wd_grant_dropped", grant, 0);
        chk("wd_err_set", timeout_err, 1);
        chk("wd_busy_gap", busy, 1);
        wait_start(3'b001, "wd_next");
        finish_frame(3);
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("wd_err_cleared", timeout_err, 0);
        idle(GAP + 2);

        // Reset mid-WAIT with pending 110
        step(3'b001, 1'b0, 1'b0, 1'b0);
        wait_start(3'b001, "rst_a");
        step(3'b110, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("rstw_pending_before", pending, 3'b110);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0);
        chk("rstw_busy", busy, 0);
        chk("rstw_grant", grant, 0);
        chk("rstw_pending", pending, 0);
        chk("rstw_start", drv_start, 0);
        step(3'b100, 1'b0, 1'b0, 1'b0);
        wait_start(3'b100, "rst_b");
        finish_frame(3);
        idle(GAP + 2);

        // Randomized traffic: alternating responsive and sluggish drivers
        for (int seg = 0; seg < 4; seg++) begin
            for (int n = 0; n < 700; n++) begin
                for (int b = 0; b < NREQ; b++) r[b] = ($urandom_range(0, 99) < 8);
                d  = ($urandom_range(0, 99) < ((seg % 2 == 0) ? 35 : 2));
                c  = ($urandom_range(0, 99) < 4);
                rs = ($urandom_range(0, 999) < 3);
                step(r, d, c, rs);
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neopixel_frame_arbiter.md
Name: neopixel_frame_arbiter

Overview:
- Shares the single neopixel game-controller driver between several frame producers: round feedback, pattern-load status, and game-over display.
- Latches one-cycle update requests and grants the driver round-robin.
- Issues a one-cycle start to the driver and waits for its done.
- Enforces a minimum inter-frame latch gap, and a watchdog that recovers from a driver that never finishes.

Parameters:
- NREQ, 3, number of requesters (2..8).
- GAP_CYCLES, 2500, idle cycles after each frame (50 us WS2812 latch at 50 MHz); 0 means no gap.
- TIMEOUT, 100000, maximum cycles in WAIT before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester update pulse; bit i = requester i wants a frame
- drv_done  in  1  driver finished transmitting the current frame (pulse or level)
- clr_err  in  1  clears timeout_err
- drv_start  out  1  one-cycle start to the driver
- grant  out  NREQ  one-hot; selects the frame source muxed into the driver
- grant_id  out  $clog2(NREQ)  binary index of grant
- pending  out  NREQ  latched, not-yet-served requests
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: all outputs 0; state IDLE. The round-robin pointer is set to NREQ-1, so requester 0 wins first. All counters are 0.
- Pending latch: pending[i] sets at the edge after req[i]=1. A repeat request while pending is merged (no queueing depth).
- States: IDLE, START, WAIT, GAP.
- IDLE, pending != 0:
  - The winner is the first set pending bit scanning upward from (last+1) mod NREQ, wrapping.
  - Next edge: state to START, grant/grant_id register the winner, last becomes the winner, pending[winner] clears.
  - A req[winner] in that same cycle wins over the clear, so pending stays 1.
- IDLE, pending == 0: stay in IDLE; grant = 0.
- START:
  - drv_start = 1 for exactly this cycle; grant is held.
  - Next state is WAIT unconditionally. drv_done is ignored in START.
- WAIT:
  - grant is held and the watchdog counter increments.
  - If drv_done = 1: next state is GAP, the gap counter loads GAP_CYCLES-1, and grant clears at that edge. If GAP_CYCLES = 0, next state is IDLE.
  - Else, if the watchdog reaches TIMEOUT-1: next state is GAP (same load), timeout_err sets, grant clears.
- GAP: the counter decrements; at 0 the next state is IDLE. Requests continue to latch during GAP.
- Request to the requester currently being served (START/WAIT/GAP): it sets pending again and is served in a later arbitration.
- Latency: req pulse in cycle t, with the arbiter IDLE and no other pending requests, gives drv_start high in cycle t+2.
- timeout_err: set by timeout, cleared by clr_err at the next edge. Set takes priority over a simultaneous clr_err.
- Reset mid-operation (any state): returns to IDLE and drops pending. drv_start is never asserted in the cycle reset is high.
- Invariants:
  - grant is one-hot or zero, and nonzero only in START/WAIT.
  - drv_start is never high on two consecutive cycles.
  - A frame never starts less than GAP_CYCLES after the previous drv_done.

Test Plan:
- Single request: NREQ=3, GAP_CYCLES=4. Pulse req=001 at t0. Expect drv_start at t0+2 with grant=001. drv_done at t0+5 gives busy high through t0+9, then IDLE.
- Simultaneous requests: req=111 in one cycle, driver done 3 cycles after each start. Expect grants in order 001, 010, 100. Each drv_start is separated by at least 4 gap cycles from the previous done. pending reaches 000.
- Round-robin fairness: after serving 010, pulse req=011 during GAP. Expect next grant=001... no: expect 100? Requester 2 is not pending, so the next grant is 001, then 010. Requester 0 is not starved behind 1.
- Re-request while served: req=001 during WAIT of requester 0. Expect pending=001 after the edge, and a second frame for requester 0 after the gap.
- Watchdog: TIMEOUT=16 with drv_done held 0. Expect WAIT to exit after 16 cycles, timeout_err=1, grant=0. Then the next pending request is served. clr_err clears timeout_err.
- Reset mid-WAIT with pending=110: the next cycle shows busy=0, grant=0, pending=0, and no drv_start. A subsequent req=100 is granted normally.
